// File: rtl/async_oneway_tx_scheduler_pkg.sv
// Shared constants, state encoding and chunk slicing for the one-way link transmitter.
// Used by the scheduler and its arbiter; ASYNC_TX_DEDUP_EN is handled in the top file.
package async_oneway_tx_scheduler_pkg;

    localparam int MESSAGE_SIZE = 16;
    localparam int CHUNK_W      = 6;
    // One extra chunk always goes out; when MESSAGE_SIZE%6==0 it is all zeros for receiver alignment.
    localparam int NCHUNK       = MESSAGE_SIZE / CHUNK_W + 1;

    typedef enum logic [2:0] {IDLE, LEAD, HI, LO, TAIL, GAP} tx_state_t;

    function automatic logic [CHUNK_W-1:0] chunk_of(input logic [MESSAGE_SIZE-1:0] m, input int k);
        logic [CHUNK_W-1:0] c;
        c = '0;
        for (int b = 0; b < CHUNK_W; b++) begin
            if (k * CHUNK_W + b < MESSAGE_SIZE) c[b] = m[k * CHUNK_W + b];
        end
        return c;
    endfunction

endpackage

// File: rtl/async_oneway_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer register itself lives in the scheduler.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx
);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/async_oneway_tx_scheduler.sv
// Transmit scheduler for the 6-bit one-way link: round-robin grant, framed return-to-zero chunks.
// Define ASYNC_TX_DEDUP_EN to skip re-sending a message identical to the last one delivered.
module async_oneway_tx_scheduler
    import async_oneway_tx_scheduler_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int HOLD_CYCLES  = 8,
    parameter int FRAME_CYCLES = 8,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                          clk_send,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*MESSAGE_SIZE-1:0] msg,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              done,
    output logic                          busy,
    output logic                          transmit_ctrl,
    output logic                          packet_pulse,
    output logic [CHUNK_W-1:0]            dout,
    output tx_state_t                     state_dbg
);

    localparam int MAX_HF = (HOLD_CYCLES > FRAME_CYCLES) ? HOLD_CYCLES : FRAME_CYCLES;
    localparam int MAX_T  = (MAX_HF > GAP_CYCLES) ? MAX_HF : GAP_CYCLES;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NCHUNK - 1);

    tx_state_t               state;
    logic [CNT_W-1:0]        cnt;
    logic [K_W-1:0]          k;
    logic [PTR_W-1:0]        ptr;
    logic [MESSAGE_SIZE-1:0] msg_q;
    logic [N_REQ-1:0]        owner;
    logic                    dup_pending;

    logic [N_REQ-1:0]        grant;
    logic [PTR_W-1:0]        grant_idx;
    logic [MESSAGE_SIZE-1:0] win_msg;
    logic [PTR_W-1:0]        next_ptr;
    logic                    skip;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign win_msg   = msg[int'(grant_idx) * MESSAGE_SIZE +: MESSAGE_SIZE];
    assign next_ptr  = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign state_dbg = state;

`ifdef ASYNC_TX_DEDUP_EN
    logic [MESSAGE_SIZE-1:0] last_msg;
    logic                    last_valid;

    // Only a frame that reached its done pulse counts as delivered.
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            last_msg   <= '0;
            last_valid <= 1'b0;
        end else if (state == TAIL && cnt == '0) begin
            last_msg   <= msg_q;
            last_valid <= 1'b1;
        end
    end

    assign skip = last_valid && (win_msg == last_msg);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            k             <= '0;
            ptr           <= '0;
            msg_q         <= '0;
            owner         <= '0;
            dup_pending   <= 1'b0;
            ack           <= '0;
            done          <= '0;
            busy          <= 1'b0;
            transmit_ctrl <= 1'b0;
            packet_pulse  <= 1'b0;
            dout          <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    // A skipped duplicate finishes here so done lands one cycle after ack.
                    if (dup_pending) begin
                        dup_pending <= 1'b0;
                        done        <= owner;
                        busy        <= 1'b0;
                    end else if (|grant) begin
                        msg_q <= win_msg;
                        owner <= grant;
                        ack   <= grant;
                        ptr   <= next_ptr;
                        busy  <= 1'b1;
                        if (skip) begin
                            dup_pending <= 1'b1;
                        end else begin
                            state         <= LEAD;
                            transmit_ctrl <= 1'b1;
                            cnt           <= FRAME_LD;
                        end
                    end
                end
                LEAD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state        <= HI;
                        k            <= '0;
                        packet_pulse <= 1'b1;
                        dout         <= chunk_of(msg_q, 0);
                        cnt          <= HOLD_LD;
                    end
                end
                HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state        <= LO;
                        packet_pulse <= 1'b0;
                        dout         <= '0;
                        cnt          <= HOLD_LD;
                    end
                end
                LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (k == K_LAST) begin
                        state <= TAIL;
                        cnt   <= FRAME_LD;
                    end else begin
                        state        <= HI;
                        k            <= k + 1'b1;
                        packet_pulse <= 1'b1;
                        dout         <= chunk_of(msg_q, int'(k) + 1);
                        cnt          <= HOLD_LD;
                    end
                end
                TAIL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state         <= GAP;
                        transmit_ctrl <= 1'b0;
                        done          <= owner;
                        cnt           <= GAP_LD;
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_async_oneway_tx_scheduler.sv
// Bench for async_oneway_tx_scheduler: directed steps with randomized messages,
// a frame observer, a round-robin model and a debounced loopback receiver.
module tb_async_oneway_tx_scheduler;
    import async_oneway_tx_scheduler_pkg::*;

    localparam int N         = 2;
    localparam int HOLD      = 4;
    localparam int FRAME     = 4;
    localparam int GAP       = 8;
    localparam int MS        = MESSAGE_SIZE;
    localparam int NCH       = MS / 6 + 1;
    localparam int FRAME_LEN = 2 * FRAME + 2 * HOLD * NCH;
    localparam logic [MS-1:0] LATE_EARLY = 16'hDEAD;
    localparam logic [MS-1:0] LATE_FINAL = 16'h5A17;

    logic              clk_send = 1'b0;
    logic              rst      = 1'b0;
    logic [N-1:0]      req      = '0;
    logic [N*MS-1:0]   msg      = '0;
    logic [N-1:0]      ack;
    logic [N-1:0]      done;
    logic              busy;
    logic              transmit_ctrl;
    logic              packet_pulse;
    logic [5:0]        dout;
    tx_state_t         state_dbg;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_ptr = 0;
    int last_fall = 0;
    bit have_last = 1'b0;
    logic [5:0] exp_q[$];
    logic [MS-1:0] cur_msg[N];

    async_oneway_tx_scheduler #(
        .N_REQ(N), .HOLD_CYCLES(HOLD), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)
    ) dut (
        .clk_send      (clk_send),
        .rst           (rst),
        .req           (req),
        .msg           (msg),
        .ack           (ack),
        .done          (done),
        .busy          (busy),
        .transmit_ctrl (transmit_ctrl),
        .packet_pulse  (packet_pulse),
        .dout          (dout),
        .state_dbg     (state_dbg)
    );

    // clock / reset block
    always #5 clk_send = ~clk_send;
    always @(posedge clk_send) cyc <= cyc + 1;

    // far-end receiver: 3-sample debounce, captures on debounced rising edge
    logic [2:0]       rx_sh = '0;
    logic             rx_db = 1'b0;
    logic             rx_tc_d = 1'b0;
    int               rx_k = 0;
    logic [6*NCH-1:0] rx_acc = '0;
    logic [MS-1:0]    read_buffer = '0;

    always @(posedge clk_send) begin
        rx_sh   <= {rx_sh[1:0], packet_pulse};
        rx_tc_d <= transmit_ctrl;
        if (rx_sh == 3'b111 && !rx_db) begin
            rx_db <= 1'b1;
            if (rx_k < NCH) rx_acc[rx_k*6 +: 6] <= dout;
            rx_k <= rx_k + 1;
        end else if (rx_sh == 3'b000) begin
            rx_db <= 1'b0;
        end
        if (transmit_ctrl && !rx_tc_d) rx_k <= 0;
        if (!transmit_ctrl && rx_tc_d) read_buffer <= rx_acc[MS-1:0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // round-robin rule: first requester at or after the pointer, pointer moves past the winner
    function automatic int rr_pick(input logic [N-1:0] r);
        int w;
        w = -1;
        for (int d = 0; d < N; d++) begin
            if (w < 0 && r[(model_ptr + d) % N]) w = (model_ptr + d) % N;
        end
        if (w >= 0) model_ptr = (w + 1) % N;
        return w;
    endfunction

    task automatic set_msg(input int s, input logic [MS-1:0] m);
        cur_msg[s] = m;
        msg[s*MS +: MS] = m;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_send);
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk_send);
        check({tag, "_outs"}, {ack, done, busy, transmit_ctrl, packet_pulse, dout}, 64'd0);
        check({tag, "_state"}, state_dbg, IDLE);
        rst = 1'b0;
        model_ptr = 0;
        have_last = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output bit ok);
        int w;
        w = 0;
        while (ack === '0 && w < 300) begin
            @(negedge clk_send);
            w++;
        end
        ok = (ack !== '0);
        if (!ok) check({tag, "_ack_timeout"}, 64'd0, 64'd1);
    endtask

    // Watches one complete frame from the ack cycle to one cycle past done.
    task automatic observe_frame(input string tag, input int src, input logic [MS-1:0] m,
                                 input bit drop, input int late_at);
        int tc_len, lead, hi_len, lo_len, hi_bad, lo_bad, viol, extra_ack;
        bit prev_pp, seen, ok;
        logic [5:0] held;
        logic [5:0] got[$];
        tc_len = 0; lead = 0; hi_len = 0; lo_len = 0; hi_bad = 0; lo_bad = 0;
        viol = 0; extra_ack = 0; prev_pp = 1'b0; seen = 1'b0; held = '0;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) exp_q.push_back(6'((64'(m) >> (6 * c)) & 64'h3f));
        wait_ack(tag, ok);
        if (!ok) return;
        check({tag, "_ack"}, ack, 64'(1) << src);
        if (have_last) check({tag, "_gap"}, 64'((cyc - last_fall) >= GAP), 64'd1);
        if (drop) req[src] = 1'b0;
        while (transmit_ctrl === 1'b1 && tc_len < 300) begin
            tc_len++;
            if (tc_len > 1 && ack !== '0) extra_ack++;
            if (tc_len == late_at) begin
                req[1] = 1'b1;
                set_msg(1, LATE_EARLY);
            end
            if (packet_pulse === 1'b1) begin
                if (!prev_pp) begin
                    if (!seen) lead = tc_len - 1;
                    else if (lo_len != HOLD) lo_bad++;
                    seen = 1'b1;
                    got.push_back(dout);
                    held = dout;
                    hi_len = 0;
                end else if (dout !== held) begin
                    viol++;
                end
                hi_len++;
            end else begin
                if (prev_pp) begin
                    if (hi_len != HOLD) hi_bad++;
                    lo_len = 0;
                end
                lo_len++;
                if (dout !== 6'd0) viol++;
            end
            prev_pp = packet_pulse;
            @(negedge clk_send);
        end
        check({tag, "_tc_len"}, tc_len, FRAME_LEN);
        check({tag, "_lead"}, lead, FRAME);
        check({tag, "_tail"}, lo_len, HOLD + FRAME);
        check({tag, "_hold_hi"}, hi_bad, 0);
        check({tag, "_hold_lo"}, lo_bad, 0);
        check({tag, "_rz"}, viol, 0);
        check({tag, "_ack_once"}, extra_ack, 0);
        check({tag, "_nchunk"}, got.size(), NCH);
        for (int c = 0; c < NCH; c++) begin
            if (c < got.size()) check($sformatf("%s_chunk%0d", tag, c), got[c], exp_q.pop_front());
        end
        check({tag, "_done"}, done, 64'(1) << src);
        check({tag, "_busy_gap"}, busy, 1);
        last_fall = cyc;
        have_last = 1'b1;
        @(negedge clk_send);
        check({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        int src, acks;
        bit ok;
        logic [MS-1:0] m;

        // reset
        #2 rst = 1'b1;
        repeat (3) @(negedge clk_send);
        check("reset_outs", {ack, done, busy, transmit_ctrl, packet_pulse, dout}, 64'd0);
        check("reset_state", state_dbg, IDLE);
        rst = 1'b0;
        repeat (2) @(negedge clk_send);

        // 1: single send
        set_msg(0, 16'hA5C3);
        req[0] = 1'b1;
        src = rr_pick(req);
        observe_frame("single", src, 16'hA5C3, 1'b1, 0);

        // 2: round-robin with both sources requesting
        do_reset("rr_rst");
        set_msg(0, MS'($urandom));
        set_msg(1, MS'($urandom));
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            src = rr_pick(req);
            check($sformatf("rr_order%0d", i), src, i % 2);
            observe_frame($sformatf("rr%0d", i), src, cur_msg[src], 1'b1, 0);
            if (i < 3) begin
                set_msg(src, MS'($urandom));
                req[src] = 1'b1;
            end
        end
        // pending request withdrawn before grant must never be acked
        req = '0;
        acks = 0;
        repeat (40) begin
            @(negedge clk_send);
            if (ack !== '0) acks++;
        end
        check("withdrawn_no_ack", acks, 0);

        // 3: reset during the second HI
        m = MS'($urandom);
        set_msg(0, m);
        req[0] = 1'b1;
        src = rr_pick(req);
        wait_ack("midrst", ok);
        if (ok) begin
            repeat (FRAME + 2 * HOLD + 1) @(negedge clk_send);
            check("midrst_in_hi", {packet_pulse, state_dbg}, {1'b1, HI});
            rst = 1'b1;
            #1;
            check("midrst_outs", {ack, done, busy, transmit_ctrl, packet_pulse, dout}, 64'd0);
            acks = 0;
            repeat (2) begin
                @(negedge clk_send);
                if (done !== '0) acks++;
            end
            check("midrst_no_done", acks, 0);
            rst = 1'b0;
            model_ptr = 0;
            have_last = 1'b0;
            src = rr_pick(req);
            observe_frame("midrst_resend", src, m, 1'b1, 0);
        end

        // 4: loopback through the debounced receiver
        set_msg(0, 16'hFFFF);
        req[0] = 1'b1;
        src = rr_pick(req);
        observe_frame("loop_ffff", src, 16'hFFFF, 1'b1, 0);
        check("loop_rx_ffff", read_buffer, 16'hFFFF);
        set_msg(0, 16'h0001);
        req[0] = 1'b1;
        src = rr_pick(req);
        observe_frame("loop_0001", src, 16'h0001, 1'b1, 0);
        check("loop_rx_0001", read_buffer, 16'h0001);

        // 5: source 1 requests during the TAIL of a source-0 frame
        m = MS'($urandom);
        set_msg(0, m);
        req[0] = 1'b1;
        src = rr_pick(req);
        observe_frame("late_src0", src, m, 1'b1, FRAME + 2 * HOLD * NCH + 2);
        check("late_no_early_ack", {ack, busy}, {2'b00, 1'b1});
        set_msg(1, LATE_FINAL);
        src = rr_pick(2'b10);
        observe_frame("late_src1", src, LATE_FINAL, 1'b1, 0);

        // 6: same message twice
        do_reset("dup_rst");
        set_msg(0, 16'h1234);
        req[0] = 1'b1;
        src = rr_pick(req);
        observe_frame("dup_first", src, 16'h1234, 1'b1, 0);
        req[0] = 1'b1;
        src = rr_pick(req);
`ifdef ASYNC_TX_DEDUP_EN
        wait_ack("dup_second", ok);
        if (ok) begin
            check("dup_ack", {ack, transmit_ctrl}, {2'b01, 1'b0});
            req[0] = 1'b0;
            @(negedge clk_send);
            check("dup_done_next", {ack, done, transmit_ctrl, packet_pulse}, {2'b00, 2'b01, 2'b00});
            acks = 0;
            repeat (FRAME_LEN) begin
                @(negedge clk_send);
                if (transmit_ctrl !== 1'b0 || packet_pulse !== 1'b0) acks++;
            end
            check("dup_no_link", acks, 0);
        end
`else
        observe_frame("dup_second", src, 16'h1234, 1'b1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
